counter_updown_mod: RTL and testbench
=====================================

# counter_updown_mod

Parametrised modulo up/down counter with synchronous load, synchronous clear, count enable and a registered wrap pulse. It generalises the team's fixed 2-bit up/down counter to arbitrary width and modulus. It is the standard counting primitive for timers, address generators and event counters elsewhere in the sequential library.

## Interface
- WIDTH, 8 — counter width in bits; legal range 1..32.
- MAX_VAL, 2**WIDTH-1 — top of count range; the count spans 0..MAX_VAL; legal range 1..2**WIDTH-1.
- RESET_VAL, 0 — value loaded by `reset` and `clear`; must be ≤ MAX_VAL.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous clear to RESET_VAL.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- en  in  1  count enable.
- mode  in  1  direction: 1 = up, 0 = down.
- count  out  WIDTH  current count (register).
- wrap  out  1  registered one-cycle pulse; count has just wrapped.
- at_max  out  1  combinational; count == MAX_VAL.
- at_min  out  1  combinational; count == 0.

## Operation
- Reset values:
  - count = RESET_VAL.
  - wrap = 0.
  - at_max and at_min are decoded from count.
- Priority per clock edge: reset > clear > load > en > hold.
- clear: count ← RESET_VAL; wrap ← 0.
- load: count ← min(load_val, MAX_VAL); wrap ← 0. The load clamps out-of-range values.
- en=1, mode=1:
  - count < MAX_VAL: count ← count+1.
  - count == MAX_VAL: count ← 0, wrap ← 1.
- en=1, mode=0:
  - count > 0: count ← count−1.
  - count == 0: count ← MAX_VAL, wrap ← 1.
- en=0: count holds; wrap ← 0.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps are possible when MAX_VAL=1 or with alternating direction; in that case wrap stays high on consecutive cycles.
- Arithmetic: the next value is computed in WIDTH+1 bits and compared against MAX_VAL. count never holds a value above MAX_VAL.
- A direction change takes effect on the same edge `mode` is sampled. There is no pipeline and no direction memory.

## Timing
- Latency is 1 cycle. count and wrap reflect the inputs sampled at the preceding rising edge.
- wrap is asserted in the same cycle count first shows the wrapped value (0 going up, MAX_VAL going down).
- at_max and at_min follow count combinationally and are valid the cycle after any update.
- Asynchronous reset asserted mid-count forces count=RESET_VAL and wrap=0 immediately. Counting resumes on the first rising edge after reset deasserts.
- clear or load asserted in a cycle where a wrap would occur suppress that wrap, so wrap=0.

## Configuration
- `COUNTER_UPDN_SAT_EN` defined:
  - Adds input port `sat` (1 bit).
  - With sat=1, counting up at MAX_VAL holds at MAX_VAL and counting down at 0 holds at 0.
  - No wrap pulse is produced in saturation; a `sat_hit` output (1 bit, registered) pulses for one cycle instead.
  - With sat=0, behaviour is identical to the wrapping mode.
- `COUNTER_UPDN_SAT_EN` undefined:
  - Neither `sat` nor `sat_hit` exists.
  - The counter always wraps.

## Structure
- Package `counter_pkg` holds:
  - localparams `DIR_UP = 1'b1` and `DIR_DN = 1'b0`.
  - A function `clamp_val(val, max)` used by the load path.
- One sub-module is natural: `counter_next_val`.
  - Combinational.
  - Inputs: count, mode, en, sat.
  - Outputs: next count and the wrap/sat event.
  - Keeps the register process in the top trivial.
- Parameter legality is checked with elaboration-time assertions: MAX_VAL range and RESET_VAL ≤ MAX_VAL.

## Test plan
- WIDTH=4, MAX_VAL=9, en=1, mode=1 from 0 for 12 cycles → count 1..9,0,1,2. wrap high only in the cycle count=0.
- Same config, mode=0 from 0 → count goes 9 with wrap=1, then 8,7,… with wrap=0.
- load=1, load_val=15, MAX_VAL=9 → count=9 next cycle and at_max=1. load and clear together → count=RESET_VAL, because clear has priority.
- Assert reset asynchronously mid-cycle while count=5 → count=RESET_VAL before the next edge, wrap=0. After release the first edge gives 1 (from RESET_VAL 0, en=1, mode=1).
- en toggled 1,0,1 with mode flipping each cycle around count=0 → correct hold, with wrap only on the 0→MAX_VAL transition.
- With `COUNTER_UPDN_SAT_EN` and sat=1, count up at MAX_VAL for 3 cycles → count stays MAX_VAL, wrap=0, sat_hit pulses each cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared direction encodings and load clamp helper for the counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Operands are widened to 32 bits so one helper serves every counter width.
  function automatic logic [31:0] clamp_val(input logic [31:0] val,
                                            input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_updown_mod_next_val.sv
// ============================================================================
// Module   : counter_next_val
// Purpose  : Combinational next-count and wrap/saturation event decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_next_val
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  input  logic             en,
  input  logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             sat_evt
);

  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  // One extra bit so the increment past MAX_VAL and the borrow below zero are visible.
  assign w_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, count} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    sat_evt    = 1'b0;
    if (en) begin
      unique case (mode)
        DIR_UP: begin
          if (w_inc > {1'b0, MAX_VAL}) begin
            if (sat) begin
              sat_evt = 1'b1;
            end else begin
              next_count = '0;
              wrap_evt   = 1'b1;
            end
          end else begin
            next_count = w_inc[WIDTH-1:0];
          end
        end
        DIR_DN: begin
          if (w_dec[WIDTH]) begin
            if (sat) begin
              sat_evt = 1'b1;
            end else begin
              next_count = MAX_VAL;
              wrap_evt   = 1'b1;
            end
          end else begin
            next_count = w_dec[WIDTH-1:0];
          end
        end
        default: next_count = count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_updown_mod.sv
// ============================================================================
// Module   : counter_updown_mod
// Purpose  : Modulo up/down counter with load, clear, enable and wrap pulse.
//            Define COUNTER_UPDN_SAT_EN to add the sat input / sat_hit output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
`ifdef COUNTER_UPDN_SAT_EN
  ,
  input  logic             sat,
  output logic             sat_hit
`endif
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
    $error("counter_updown_mod: WIDTH must be 1..32");
  end
  if (MAX_VAL == '0) begin : g_chk_max
    $error("counter_updown_mod: MAX_VAL must be at least 1");
  end
  if (RESET_VAL > MAX_VAL) begin : g_chk_rst
    $error("counter_updown_mod: RESET_VAL must not exceed MAX_VAL");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] w_next_count;
  logic             w_wrap_evt;
  logic             w_sat;

`ifdef COUNTER_UPDN_SAT_EN
  logic             w_sat_evt;
  logic             sat_hit_q;
  logic             sat_hit_d;
  assign w_sat = sat;
`else
  logic             w_sat_evt_unused;
  assign w_sat = 1'b0;
`endif

  counter_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next_val (
    .count      (count_q),
    .mode       (mode),
    .en         (en),
    .sat        (w_sat),
    .next_count (w_next_count),
    .wrap_evt   (w_wrap_evt),
`ifdef COUNTER_UPDN_SAT_EN
    .sat_evt    (w_sat_evt)
`else
    .sat_evt    (w_sat_evt_unused)
`endif
  );

  // Clear and load both zero the event pulses, so they suppress a pending wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
`ifdef COUNTER_UPDN_SAT_EN
    sat_hit_d = 1'b0;
`endif
    if (clear) begin
      count_d = RESET_VAL;
    end else if (load) begin
      count_d = WIDTH'(clamp_val(32'(load_val), 32'(MAX_VAL)));
    end else begin
      count_d = w_next_count;
      wrap_d  = w_wrap_evt;
`ifdef COUNTER_UPDN_SAT_EN
      sat_hit_d = w_sat_evt;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef COUNTER_UPDN_SAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_hit_q <= 1'b0;
    end else begin
      sat_hit_q <= sat_hit_d;
    end
  end
  assign sat_hit = sat_hit_q;
`endif

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
// ============================================================================
// Module   : tb_counter_updown_mod
// Purpose  : Scoreboard bench for counter_updown_mod (WIDTH=4, MAX_VAL=9).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_updown_mod;

  localparam int unsigned W  = 4;
  localparam logic [3:0]  MX = 4'd9;
  localparam logic [3:0]  RV = 4'd0;

  typedef struct packed {
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       md;
    logic       st;
  } stim_t;

  typedef struct packed {
    logic [3:0] cnt;
    logic       wrap;
    logic       amax;
    logic       amin;
    logic       shit;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       sat = 1'b0;
  logic [3:0] count;
  logic       wrap;
  logic       at_max;
  logic       at_min;
  logic       sat_hit;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [3:0] m_cnt = RV;

  always #5 clk = ~clk;

  counter_updown_mod #(
    .WIDTH     (W),
    .MAX_VAL   (MX),
    .RESET_VAL (RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .mode     (mode),
    .count    (count),
    .wrap     (wrap),
    .at_max   (at_max),
    .at_min   (at_min)
`ifdef COUNTER_UPDN_SAT_EN
    ,
    .sat      (sat),
    .sat_hit  (sat_hit)
`endif
  );

`ifndef COUNTER_UPDN_SAT_EN
  assign sat_hit = 1'b0;
`endif

  // Drive one cycle of stimulus, advance the reference model and queue its result.
  task automatic drive_cycle(input stim_t s);
    exp_t e;
    @(negedge clk);
    clear = s.clr; load = s.ld; load_val = s.lv; en = s.en; mode = s.md; sat = s.st;
    e = '0;
    if (s.clr) begin
      m_cnt = RV;
    end else if (s.ld) begin
      m_cnt = (s.lv > MX) ? MX : s.lv;
    end else if (s.en && s.md) begin
      if (m_cnt == MX) begin
        if (s.st) e.shit = 1'b1; else begin m_cnt = 4'd0; e.wrap = 1'b1; end
      end else m_cnt = m_cnt + 4'd1;
    end else if (s.en) begin
      if (m_cnt == 4'd0) begin
        if (s.st) e.shit = 1'b1; else begin m_cnt = MX; e.wrap = 1'b1; end
      end else m_cnt = m_cnt - 4'd1;
    end
    e.cnt  = m_cnt;
    e.amax = (m_cnt == MX);
    e.amin = (m_cnt == 4'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== RV || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset count=%0d wrap=%0b expected count=%0d wrap=0", count, wrap, RV);
    end
    checks++;
    if (at_min !== 1'b1 || at_max !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags at_min=%0b at_max=%0b expected 1 0", at_min, at_max);
    end
    @(negedge clk);
    reset = 1'b0;
    m_cnt = RV;
  endtask

  task automatic test_count_up();
    exp_t e;
    drive_cycle('{clr:1'b1, ld:1'b0, lv:4'd0, en:1'b0, md:1'b1, st:1'b0});
    void'(sb.pop_front());
    for (int i = 0; i < 12; i++) begin
      drive_cycle('{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b1, st:1'b0});
      e = sb.pop_front();
      checks++;
      if (count !== e.cnt || wrap !== e.wrap) begin
        errors++;
        $display("FAIL up[%0d] count=%0d wrap=%0b expected count=%0d wrap=%0b", i, count, wrap, e.cnt, e.wrap);
      end
      checks++;
      if (at_max !== e.amax || at_min !== e.amin) begin
        errors++;
        $display("FAIL up_flags[%0d] at_max=%0b at_min=%0b expected %0b %0b", i, at_max, at_min, e.amax, e.amin);
      end
    end
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL up_final count=%0d expected 2", count);
    end
  endtask

  task automatic test_count_down();
    exp_t e;
    drive_cycle('{clr:1'b1, ld:1'b0, lv:4'd0, en:1'b0, md:1'b0, st:1'b0});
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive_cycle('{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b0, st:1'b0});
      e = sb.pop_front();
      checks++;
      if (count !== e.cnt || wrap !== e.wrap || at_max !== e.amax || at_min !== e.amin) begin
        errors++;
        $display("FAIL down[%0d] count=%0d wrap=%0b max=%0b min=%0b expected count=%0d wrap=%0b max=%0b min=%0b",
                 i, count, wrap, at_max, at_min, e.cnt, e.wrap, e.amax, e.amin);
      end
    end
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL down_final count=%0d expected 5", count);
    end
  endtask

  task automatic test_load_clear();
    exp_t  e;
    stim_t tbl [8];
    tbl[0] = '{clr:1'b0, ld:1'b1, lv:4'd15, en:1'b0, md:1'b0, st:1'b0};
    tbl[1] = '{clr:1'b0, ld:1'b1, lv:4'd3,  en:1'b1, md:1'b1, st:1'b0};
    tbl[2] = '{clr:1'b1, ld:1'b1, lv:4'd7,  en:1'b1, md:1'b1, st:1'b0};
    tbl[3] = '{clr:1'b0, ld:1'b1, lv:4'd9,  en:1'b0, md:1'b0, st:1'b0};
    tbl[4] = '{clr:1'b1, ld:1'b0, lv:4'd0,  en:1'b1, md:1'b1, st:1'b0};
    tbl[5] = '{clr:1'b0, ld:1'b1, lv:4'd4,  en:1'b1, md:1'b0, st:1'b0};
    tbl[6] = '{clr:1'b0, ld:1'b1, lv:4'd10, en:1'b1, md:1'b0, st:1'b0};
    tbl[7] = '{clr:1'b0, ld:1'b0, lv:4'd0,  en:1'b0, md:1'b1, st:1'b0};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(tbl[i]);
      e = sb.pop_front();
      checks++;
      if (count !== e.cnt || wrap !== e.wrap || at_max !== e.amax || at_min !== e.amin) begin
        errors++;
        $display("FAIL load[%0d] count=%0d wrap=%0b max=%0b min=%0b expected count=%0d wrap=%0b max=%0b min=%0b",
                 i, count, wrap, at_max, at_min, e.cnt, e.wrap, e.amax, e.amin);
      end
      if (i == 0) begin
        checks++;
        if (count !== 4'd9 || at_max !== 1'b1) begin
          errors++;
          $display("FAIL load_clamp count=%0d at_max=%0b expected 9 1", count, at_max);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive_cycle('{clr:1'b1, ld:1'b0, lv:4'd0, en:1'b0, md:1'b1, st:1'b0});
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive_cycle('{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b1, st:1'b0});
      e = sb.pop_front();
      checks++;
      if (count !== e.cnt || wrap !== e.wrap) begin
        errors++;
        $display("FAIL pre_reset[%0d] count=%0d wrap=%0b expected count=%0d wrap=%0b", i, count, wrap, e.cnt, e.wrap);
      end
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== RV || wrap !== 1'b0 || at_min !== 1'b1) begin
      errors++;
      $display("FAIL async_reset count=%0d wrap=%0b at_min=%0b expected count=%0d wrap=0 at_min=1", count, wrap, at_min, RV);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_cnt = 4'd1;
    checks++;
    if (count !== 4'd1 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL post_reset count=%0d wrap=%0b expected count=1 wrap=0", count, wrap);
    end
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    stim_t tbl [8];
    tbl[0] = '{clr:1'b1, ld:1'b0, lv:4'd0, en:1'b0, md:1'b0, st:1'b0};
    tbl[1] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b0, st:1'b0};
    tbl[2] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b0, md:1'b1, st:1'b0};
    tbl[3] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b1, st:1'b0};
    tbl[4] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b0, st:1'b0};
    tbl[5] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b0, md:1'b0, st:1'b0};
    tbl[6] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b1, st:1'b0};
    tbl[7] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b1, st:1'b0};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(tbl[i]);
      e = sb.pop_front();
      checks++;
      if (count !== e.cnt || wrap !== e.wrap || at_max !== e.amax || at_min !== e.amin) begin
        errors++;
        $display("FAIL toggle[%0d] count=%0d wrap=%0b max=%0b min=%0b expected count=%0d wrap=%0b max=%0b min=%0b",
                 i, count, wrap, at_max, at_min, e.cnt, e.wrap, e.amax, e.amin);
      end
    end
  endtask

`ifdef COUNTER_UPDN_SAT_EN
  task automatic test_saturate();
    exp_t  e;
    stim_t tbl [7];
    tbl[0] = '{clr:1'b0, ld:1'b1, lv:4'd9, en:1'b0, md:1'b1, st:1'b1};
    tbl[1] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b1, st:1'b1};
    tbl[2] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b1, st:1'b1};
    tbl[3] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b1, st:1'b1};
    tbl[4] = '{clr:1'b1, ld:1'b0, lv:4'd0, en:1'b0, md:1'b0, st:1'b1};
    tbl[5] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b0, st:1'b1};
    tbl[6] = '{clr:1'b0, ld:1'b0, lv:4'd0, en:1'b1, md:1'b0, st:1'b0};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(tbl[i]);
      e = sb.pop_front();
      checks++;
      if (count !== e.cnt || wrap !== e.wrap || sat_hit !== e.shit) begin
        errors++;
        $display("FAIL sat[%0d] count=%0d wrap=%0b sat_hit=%0b expected count=%0d wrap=%0b sat_hit=%0b",
                 i, count, wrap, sat_hit, e.cnt, e.wrap, e.shit);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clear();
    test_async_reset();
    test_back_to_back();
`ifdef COUNTER_UPDN_SAT_EN
    test_saturate();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
